// File: rtl/ultrasonido_distancia_if.sv
// Bundle between the echo counter stage, the game logic and the distance converter.
interface ultrasonido_distancia_if #(
   parameter int COUNT_W = 16,
   parameter int DIST_W  = 9
);
   logic [COUNT_W-1:0] count;
   logic               calculate;
   logic [DIST_W-1:0]  threshold;
   logic [DIST_W-1:0]  dist_raw;
   logic [DIST_W-1:0]  dist_cm;
   logic               dist_valid;
   logic               range_err;
   logic               near;
   logic               busy;
   logic               overrun;

   modport master (
      output count, calculate, threshold,
      input  dist_raw, dist_cm, dist_valid, range_err, near, busy, overrun
   );

   modport slave (
      input  count, calculate, threshold,
      output dist_raw, dist_cm, dist_valid, range_err, near, busy, overrun
   );
endinterface

// File: rtl/ultrasonido_distancia.sv
// Echo ticks to centimetres: serial restoring divider, range check and a 4-sample
// moving average, with registered results and a one-cycle valid strobe.
module ultrasonido_distancia #(
   parameter int COUNT_W = 16,
   parameter int DIST_W  = 9,
   parameter int DIV     = 58,
   parameter int MAX_CM  = 400
) (
   input logic                   CLKOUT,
   input logic                   reset,
   ultrasonido_distancia_if.slave bus
);
   localparam int BIT_W = $clog2(COUNT_W + 1);
   localparam int SUM_W = DIST_W + 2;
   localparam logic [COUNT_W:0]   DIV_C = (COUNT_W + 1)'(DIV);
   localparam logic [COUNT_W-1:0] MAX_Q = COUNT_W'(MAX_CM);
   localparam logic [DIST_W-1:0]  MAX_D = DIST_W'(MAX_CM);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_AVG  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t state_r, state_s;

   logic                       calc_prev_r;
   logic [COUNT_W-1:0]         dividend_r, dividend_s;
   logic [COUNT_W-1:0]         quotient_r, quotient_s;
   logic [COUNT_W:0]           rem_r, rem_s;
   logic [BIT_W-1:0]           bit_cnt_r, bit_cnt_s;
   logic                       count_zero_r, count_zero_s;
   logic [3:0][DIST_W-1:0]     buf_r, buf_s;
   logic                       fill_r, fill_s;
   logic [1:0]                 wptr_r, wptr_s;
   logic [DIST_W-1:0]          dist_raw_r, dist_raw_s;
   logic [DIST_W-1:0]          dist_cm_r, dist_cm_s;
   logic                       dist_valid_r, dist_valid_s;
   logic                       range_err_r, range_err_s;
   logic                       near_r, near_s;
   logic                       busy_r, busy_s;
   logic                       overrun_r, overrun_s;

   logic                       edge_s;
   logic [COUNT_W:0]           rem_shift_s;
   logic                       sub_ok_s;
   logic                       err_s;
   logic [SUM_W-1:0]           sum_s;

   assign edge_s      = bus.calculate & ~calc_prev_r;
   assign rem_shift_s = {rem_r[COUNT_W-1:0], dividend_r[COUNT_W-1]};
   assign sub_ok_s    = (rem_shift_s >= DIV_C);
   assign err_s       = count_zero_r | (quotient_r > MAX_Q);

   // State register
   always_ff @(posedge CLKOUT) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               state_s = ST_DIV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (bit_cnt_r == BIT_W'(1)) begin
               state_s = ST_AVG;
            end else begin
               state_s = ST_DIV;
            end
         end
         ST_AVG:  state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath and output next values; results are loaded in AVG so they show in DONE
   always_comb begin
      dividend_s   = dividend_r;
      quotient_s   = quotient_r;
      rem_s        = rem_r;
      bit_cnt_s    = bit_cnt_r;
      count_zero_s = count_zero_r;
      buf_s        = buf_r;
      fill_s       = fill_r;
      wptr_s       = wptr_r;
      dist_raw_s   = dist_raw_r;
      dist_cm_s    = dist_cm_r;
      dist_valid_s = 1'b0;
      range_err_s  = range_err_r;
      near_s       = near_r;
      busy_s       = busy_r;
      overrun_s    = overrun_r;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               dividend_s   = bus.count;
               quotient_s   = '0;
               rem_s        = '0;
               bit_cnt_s    = BIT_W'(COUNT_W);
               count_zero_s = (bus.count == '0);
               busy_s       = 1'b1;
            end else begin
               busy_s       = 1'b0;
            end
         end
         ST_DIV: begin
            if (sub_ok_s) begin
               rem_s = rem_shift_s - DIV_C;
            end else begin
               rem_s = rem_shift_s;
            end
            quotient_s = {quotient_r[COUNT_W-2:0], sub_ok_s};
            dividend_s = {dividend_r[COUNT_W-2:0], 1'b0};
            bit_cnt_s  = bit_cnt_r - BIT_W'(1);
         end
         ST_AVG: begin
            dist_valid_s = 1'b1;
            range_err_s  = err_s;
            if (err_s) begin
               dist_raw_s = count_zero_r ? '0 : MAX_D;
            end else begin
               dist_raw_s = quotient_r[DIST_W-1:0];
               if (!fill_r) begin
                  buf_s  = {4{quotient_r[DIST_W-1:0]}};
                  fill_s = 1'b1;
               end else begin
                  buf_s[wptr_r] = quotient_r[DIST_W-1:0];
                  wptr_s        = wptr_r + 2'd1;
               end
            end
         end
         ST_DONE: begin
            busy_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
      sum_s = SUM_W'(buf_s[0]) + SUM_W'(buf_s[1]) + SUM_W'(buf_s[2]) + SUM_W'(buf_s[3]);
      if ((state_r == ST_AVG) && !err_s) begin
         dist_cm_s = sum_s[SUM_W-1:2];
         near_s    = (sum_s[SUM_W-1:2] < bus.threshold);
      end else begin
         dist_cm_s = dist_cm_r;
         near_s    = near_r;
      end
      // A new edge during a conversion is only flagged, never acted on
      if (edge_s && (state_r != ST_IDLE)) begin
         overrun_s = 1'b1;
      end else begin
         overrun_s = overrun_r;
      end
   end

   // Datapath and output registers
   always_ff @(posedge CLKOUT) begin
      if (reset) begin
         calc_prev_r  <= 1'b0;
         dividend_r   <= '0;
         quotient_r   <= '0;
         rem_r        <= '0;
         bit_cnt_r    <= '0;
         count_zero_r <= 1'b0;
         buf_r        <= '0;
         fill_r       <= 1'b0;
         wptr_r       <= 2'd0;
         dist_raw_r   <= '0;
         dist_cm_r    <= '0;
         dist_valid_r <= 1'b0;
         range_err_r  <= 1'b0;
         near_r       <= 1'b0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         calc_prev_r  <= bus.calculate;
         dividend_r   <= dividend_s;
         quotient_r   <= quotient_s;
         rem_r        <= rem_s;
         bit_cnt_r    <= bit_cnt_s;
         count_zero_r <= count_zero_s;
         buf_r        <= buf_s;
         fill_r       <= fill_s;
         wptr_r       <= wptr_s;
         dist_raw_r   <= dist_raw_s;
         dist_cm_r    <= dist_cm_s;
         dist_valid_r <= dist_valid_s;
         range_err_r  <= range_err_s;
         near_r       <= near_s;
         busy_r       <= busy_s;
         overrun_r    <= overrun_s;
      end
   end

   assign bus.dist_raw   = dist_raw_r;
   assign bus.dist_cm    = dist_cm_r;
   assign bus.dist_valid = dist_valid_r;
   assign bus.range_err  = range_err_r;
   assign bus.near       = near_r;
   assign bus.busy       = busy_r;
   assign bus.overrun    = overrun_r;
endmodule

// File: doc/ultrasonido_distancia.md
Name: ultrasonido_distancia

Overview:
- Downstream stage of the ultrasonic echo counter.
- Consumes the echo-width count and its `calculate` completion flag, and converts ticks to centimetres with a sequential shift-subtract divider.
- Applies range checking and a 4-sample moving average, then presents a registered distance with a one-cycle valid strobe and a proximity flag for game logic.

Parameters:
- COUNT_W, 16, width of incoming echo count
- DIST_W, 9, width of distance outputs (cm)
- DIV, 58, echo ticks per centimetre (round trip); constant divisor, must be ≥1
- MAX_CM, 400, largest legal distance; must be ≤ 2^DIST_W-1

Ports:
- CLKOUT  in  1  clock, same domain as the echo counter
- reset  in  1  synchronous, active-high
- count  in  COUNT_W  echo width in ticks from the counter stage
- calculate  in  1  level from the counter stage; its rising edge means `count` is final
- threshold  in  DIST_W  proximity threshold in cm
- dist_raw  out  DIST_W  latest single-sample distance, saturated to MAX_CM
- dist_cm  out  DIST_W  4-sample averaged distance
- dist_valid  out  1  one-cycle strobe; all result outputs are updated in this cycle
- range_err  out  1  latest sample was out of range
- near  out  1  dist_cm < threshold
- busy  out  1  conversion in progress
- overrun  out  1  sticky; a `calculate` edge arrived while busy

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is CLKOUT.
- Reset values:
  - all outputs 0, FSM in IDLE
  - calc_prev = 0, average buffer empty (fill flag = 0)
- Edge detect: `edge = calculate & ~calc_prev`. calc_prev is registered every cycle.
- FSM states: IDLE, DIV, AVG, DONE.
- IDLE: on edge (call this cycle N), latch `count` into the dividend register, clear quotient/remainder, load a bit counter with COUNT_W, busy←1, go to DIV.
- DIV: one restoring shift-subtract step per cycle, MSB first, for COUNT_W cycles.
  - Remainder width is COUNT_W+1.
  - After the last step, go to AVG.
- AVG: compute the sample classification in one cycle.
  - If latched count = 0 or quotient > MAX_CM: sample is in error.
    - dist_raw = 0 if count = 0, else MAX_CM.
    - range_err = 1.
    - Average buffer is not written.
  - Otherwise: dist_raw = quotient, range_err = 0.
    - If fill flag = 0, write the sample into all 4 entries and set fill flag.
    - Else overwrite the oldest entry (2-bit write pointer, wraps 3→0).
  - Sum width is DIST_W+2; dist_cm = sum>>2 (truncating).
- DONE: dist_valid = 1 for exactly this cycle (N+COUNT_W+2).
  - All result outputs are registered and change only in this cycle.
  - near is recomputed from the new dist_cm and the current threshold.
  - On an error sample, dist_cm and near hold their previous values.
  - busy←0, go to IDLE.
- Edge while busy (DIV/AVG/DONE): the edge is ignored, overrun←1, and the in-flight conversion is unaffected.
  - overrun clears only on reset.
- Calculate held high: produces no further conversions until it drops and rises again.
- Reset mid-conversion: aborts immediately. Next cycle is IDLE, all outputs 0, no dist_valid, fill flag cleared.
- No combinational path from any input to any output.

Test Plan:
- Reset then count=5800, raise calculate → dist_valid exactly 18 cycles after the edge; dist_raw=100, dist_cm=100, range_err=0, busy high for cycles N+1..N+18.
- Follow with count=5858 → dist_raw=101, dist_cm=(100·3+101)>>2=100.
- Follow with 3 more samples of 5858 → dist_cm=101 after the 4th entry is replaced; threshold=102 → near=1; threshold=101 → near=0 on the next valid.
- count=23258 (401 cm) → dist_raw=400, range_err=1, dist_cm and near unchanged.
- count=0 → dist_raw=0, range_err=1.
- count=57 → dist_raw=0, range_err=0.
- Second calculate edge 5 cycles into a conversion → single dist_valid, result from the first count, overrun=1 until reset.
- Assert reset at cycle N+8 of a conversion → no dist_valid; all outputs 0.
- Post-reset count=2900 → dist_cm=50, confirming prefill.
